// File: rtl/fifo_w_ctrl_if.sv
// fifo_w_ctrl_if: write-side control bundle between the data source and the FIFO write controller
interface fifo_w_ctrl_if #(parameter int ADDR_W = 3);
    logic              w_en;
    logic [ADDR_W:0]   r_gray;
    logic [ADDR_W-1:0] w_addr;
    logic              w_full;
    logic              w_almost_full;
    logic [ADDR_W:0]   w_level;
    logic [ADDR_W:0]   w_gray;
    logic              w_ovf;
    modport master (output w_en, r_gray, input w_addr, w_full, w_almost_full, w_level, w_gray, w_ovf);
    modport slave  (input w_en, r_gray, output w_addr, w_full, w_almost_full, w_level, w_gray, w_ovf);
endinterface

// File: rtl/fifo_w_ctrl.sv
// fifo_w_ctrl: write-domain pointer, full/almost-full/level flags and read-pointer synchronizer for a dual-clock FIFO
module fifo_w_ctrl #(
    parameter int ADDR_W    = 3,
    parameter int AF_MARGIN = 2
) (
    input logic           w_clk,
    input logic           w_rst_n,
    fifo_w_ctrl_if.slave  bus
);
    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W:0] AF_TH = (ADDR_W+1)'(DEPTH - AF_MARGIN);

    logic [ADDR_W:0] bin_q, bin_d, gray_q, gray_d, wq1_q, wq2_q, rbin_s, level_q, level_d;
    logic            full_q, full_d, af_q, af_d, ovf_q, ovf_d, push;

    // Next pointer and flags; full compares against the read pointer shifted by DEPTH in Gray form
    always_comb begin
        push   = bus.w_en & ~full_q;
        bin_d  = bin_q + {{ADDR_W{1'b0}}, push};
        gray_d = bin_d ^ (bin_d >> 1);
        rbin_s = '0;
        for (int i = 0; i <= ADDR_W; i++) rbin_s[i] = ^(wq2_q >> i);
        full_d  = gray_d == {~wq2_q[ADDR_W:ADDR_W-1], wq2_q[ADDR_W-2:0]};
        level_d = bin_d - rbin_s;
        af_d    = level_d >= AF_TH;
        ovf_d   = ovf_q | (bus.w_en & full_q);
    end

    // State registers and two-flop synchronizer for the read-domain Gray pointer
    always_ff @(posedge w_clk) begin
        if (!w_rst_n) begin
            bin_q   <= '0;
            gray_q  <= '0;
            wq1_q   <= '0;
            wq2_q   <= '0;
            level_q <= '0;
            full_q  <= 1'b0;
            af_q    <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            bin_q   <= bin_d;
            gray_q  <= gray_d;
            wq1_q   <= bus.r_gray;
            wq2_q   <= wq1_q;
            level_q <= level_d;
            full_q  <= full_d;
            af_q    <= af_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus.w_addr        = bin_q[ADDR_W-1:0];
    assign bus.w_gray        = gray_q;
    assign bus.w_level       = level_q;
    assign bus.w_full        = full_q;
    assign bus.w_almost_full = af_q;
    assign bus.w_ovf         = ovf_q;
endmodule

// File: tb/tb_fifo_w_ctrl.sv
// tb_fifo_w_ctrl: directed and random checks of the FIFO write controller against a pointer-count model
module tb_fifo_w_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;

    // Model state: write count mod 16, read pointer as seen after each synchronizer stage, flags
    int   m_wr = 0, m_q1 = 0, m_q2 = 0, m_lvl = 0, rp = 0;
    bit   m_full = 0, m_af = 0, m_ovf = 0;

    fifo_w_ctrl_if #(.ADDR_W(3)) bus();
    fifo_w_ctrl #(.ADDR_W(3), .AF_MARGIN(2)) dut (.w_clk(clk), .w_rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    function automatic logic [3:0] gray(input int b);
        logic [3:0] v;
        v = 4'(b);
        return v ^ (v >> 1);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all();
        chk("w_addr", 32'(bus.w_addr), 32'(m_wr % 8));
        chk("w_gray", 32'(bus.w_gray), 32'(gray(m_wr)));
        chk("w_level", 32'(bus.w_level), 32'(m_lvl));
        chk("w_full", 32'(bus.w_full), 32'(m_full));
        chk("w_almost_full", 32'(bus.w_almost_full), 32'(m_af));
        chk("w_ovf", 32'(bus.w_ovf), 32'(m_ovf));
    endtask

    task automatic step(input logic rn, input logic en, input int r);
        rst_n = rn;
        bus.w_en = en;
        bus.r_gray = gray(r);
        @(posedge clk);
        if (!rn) begin
            m_wr = 0; m_q1 = 0; m_q2 = 0; m_lvl = 0;
            m_full = 0; m_af = 0; m_ovf = 0;
        end else begin
            if (en && m_full) m_ovf = 1;
            if (en && !m_full) m_wr = (m_wr + 1) % 16;
            m_lvl = (m_wr - m_q2 + 16) % 16;
            m_full = (m_lvl == 8);
            m_af = (m_lvl >= 6);
            m_q2 = m_q1;
            m_q1 = r;
        end
        #1;
        chk_all();
    endtask

    initial begin
        bus.w_en = 1'b0;
        bus.r_gray = '0;
        // reset held with activity on the inputs; r_gray 0101 is read pointer 6
        for (int i = 0; i < 3; i++) step(0, 1, 6);
        for (int i = 0; i < 2; i++) step(1, 0, 0);
        // fill eight entries
        for (int i = 1; i <= 8; i++) begin
            step(1, 1, 0);
            if (i == 6) begin
                chk("af_at_6", 32'(bus.w_almost_full), 32'd1);
                chk("level_at_6", 32'(bus.w_level), 32'd6);
            end
        end
        chk("full_gray", 32'(bus.w_gray), 32'hC);
        chk("full_level", 32'(bus.w_level), 32'd8);
        // overflow attempts while full
        for (int i = 0; i < 2; i++) step(1, 1, 0);
        chk("ovf_addr", 32'(bus.w_addr), 32'd0);
        chk("ovf_gray", 32'(bus.w_gray), 32'hC);
        step(1, 0, 0);
        chk("ovf_sticky", 32'(bus.w_ovf), 32'd1);
        // one read; full clears on the third edge
        rp = 1;
        step(1, 0, rp);
        chk("rel_edge1", 32'(bus.w_full), 32'd1);
        step(1, 0, rp);
        chk("rel_edge2", 32'(bus.w_full), 32'd1);
        step(1, 0, rp);
        chk("rel_edge3_full", 32'(bus.w_full), 32'd0);
        chk("rel_edge3_level", 32'(bus.w_level), 32'd7);
        chk("rel_push_addr", 32'(bus.w_addr), 32'd0);
        step(1, 1, rp);
        chk("rel_refull", 32'(bus.w_full), 32'd1);
        // drain to level 5 with overflow still flagged, then reset mid-operation
        for (int i = 2; i <= 4; i++) begin
            rp = i;
            step(1, 0, rp);
        end
        for (int i = 0; i < 2; i++) step(1, 0, rp);
        chk("mid_level", 32'(bus.w_level), 32'd5);
        chk("mid_af", 32'(bus.w_almost_full), 32'd0);
        chk("mid_ovf", 32'(bus.w_ovf), 32'd1);
        step(0, 0, rp);
        chk("mid_rst_level", 32'(bus.w_level), 32'd0);
        rp = 0;
        step(1, 1, rp);
        chk("mid_push_addr", 32'(bus.w_addr), 32'd1);
        step(0, 0, 0);
        // wrap: reader trails the writer by two entries
        for (int i = 1; i <= 20; i++) begin
            step(1, 1, (m_wr + 14) % 16);
            if (i == 8) chk("wrap_gray8", 32'(bus.w_gray), 32'hC);
            if (i == 16) chk("wrap_gray16", 32'(bus.w_gray), 32'h0);
            chk("wrap_nofull", 32'(bus.w_full), 32'd0);
        end
        // random traffic; reader advances only when not empty
        step(0, 0, 0);
        rp = 0;
        for (int i = 0; i < 400; i++) begin
            if (rp != m_wr && $urandom_range(0, 1) == 1) rp = (rp + 1) % 16;
            step(1, 1'($urandom_range(0, 2) != 0), rp);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
